// File: rtl/neuron_readout_streamer.sv
// Readout engine: issues neuron-buffer read instructions over an address range and
// streams the returned words to the host through a credit-managed FWFT FIFO.
module neuron_readout_streamer #(
  parameter int          depth    = 3,
  parameter int          W        = 16,
  parameter int          ABuffer  = 11,
  parameter int          insW     = (depth > 2) ? depth : 2,
  parameter int          insD     = ((1 << depth) > W) ? (1 << depth) : W,
  parameter int          insWidth = 4 + 2 + 2 * insW + insD,
  parameter logic [3:0]  READ_OP  = 4'b0101,
  parameter int          LAT      = 2,
  parameter int          FLOG     = 2
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                start,
  input  logic [ABuffer-1:0]  baseAddr,
  input  logic [ABuffer:0]    count,
  input  logic [depth-1:0]    lane,
  input  logic                bufSel,
  output logic                busy,
  output logic                done,
  output logic [insWidth-1:0] instruction,
  input  logic [W-1:0]        dataIn,
  output logic [W-1:0]        outData,
  output logic                outValid,
  input  logic                outReady,
  output logic                outLast,
  output logic [1:0]          dbg_state_o
);

  // Stream handshake: a word transfers on any rising edge where outValid && outReady;
  // outValid never drops and outData/outLast never change while a word waits.

  localparam int FDEPTH = 1 << FLOG;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [ABuffer-1:0]   base_q, base_d;
  logic [ABuffer:0]     cnt_q, cnt_d;
  logic [ABuffer:0]     idx_q, idx_d;
  logic [depth-1:0]     lane_q, lane_d;
  logic                 buf_q, buf_d;
  logic [insWidth-1:0]  instr_q, instr_d;

  // Tag stage 0 lines up with instr_q; stage LAT is the cycle its data is on dataIn.
  logic [LAT:0]         tag_vld_q, tag_last_q;

  logic [W-1:0]         fifo_data_q [FDEPTH];
  logic [FDEPTH-1:0]    fifo_last_q;
  logic [FLOG-1:0]      wptr_q, rptr_q;
  logic [FLOG:0]        occ_q;

  logic                 push, pop, issue, issue_last, issue_req;
  logic                 use_in;
  logic [ABuffer-1:0]   sel_base, iss_addr;
  logic [ABuffer:0]     sel_cnt, sel_idx;
  logic [depth-1:0]     sel_lane;
  logic                 sel_buf;
  int                   credits;

  // The first read leaves straight from IDLE so it is visible the cycle after start.
  assign use_in   = (state_q == S_IDLE);
  assign sel_base = use_in ? baseAddr : base_q;
  assign sel_cnt  = use_in ? count    : cnt_q;
  assign sel_idx  = use_in ? '0       : idx_q;
  assign sel_lane = use_in ? lane     : lane_q;
  assign sel_buf  = use_in ? bufSel   : buf_q;
  assign iss_addr = sel_base + sel_idx[ABuffer-1:0];

  assign outValid = (occ_q != '0);
  assign pop      = outValid & outReady;
  assign push     = tag_vld_q[LAT];
  assign outData  = outValid ? fifo_data_q[rptr_q] : '0;
  assign outLast  = outValid & fifo_last_q[rptr_q];

  // A word popped this edge frees its slot for the read issued at the same edge.
  always_comb begin
    credits = int'(occ_q) - int'(pop);
    for (int s = 0; s <= LAT; s++) begin
      credits = credits + int'(tag_vld_q[s]);
    end
  end

  assign issue_req  = ((state_q == S_IDLE) && start && (count != '0)) || (state_q == S_ISSUE);
  assign issue      = issue_req && (credits < FDEPTH);
  assign issue_last = (sel_idx == sel_cnt - 1'b1);

  always_comb begin
    instr_d = '0;
    if (issue) begin
      instr_d = {READ_OP, sel_buf, 1'b0, insW'(sel_lane), {insW{1'b0}}, insD'(iss_addr)};
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            base_d  = baseAddr;
            cnt_d   = count;
            lane_d  = lane;
            buf_d   = bufSel;
            idx_d   = issue ? {{ABuffer{1'b0}}, 1'b1} : '0;
            state_d = (issue && issue_last) ? S_DRAIN : S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          idx_d = idx_q + 1'b1;
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && outLast) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      lane_q     <= '0;
      buf_q      <= 1'b0;
      instr_q    <= '0;
      tag_vld_q  <= '0;
      tag_last_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      buf_q      <= buf_d;
      instr_q    <= instr_d;
      tag_vld_q  <= {tag_vld_q[LAT-1:0], issue};
      tag_last_q <= {tag_last_q[LAT-1:0], issue & issue_last};
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      occ_q <= occ_q + {{FLOG{1'b0}}, push} - {{FLOG{1'b0}}, pop};
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_data_q[wptr_q] <= dataIn;
      fifo_last_q[wptr_q] <= tag_last_q[LAT];
    end
  end

  assign instruction = instr_q;
  assign dbg_state_o = state_q;

endmodule
